timebase_prescaler: RTL and testbench

- Free-running 27-bit prescaler counter that produces the count bus consumed by the 2-second terminal-count comparator stage.
- Wraps at a programmable terminal value and emits a registered one-cycle tick per period.
- Emits a blink toggle for the display colon.
- Small run/hold/idle control FSM lets the time-set logic pause, resume and clear the timebase.

---
 rtl/timebase_prescaler.sv | 132 +++++++++++++
 tb/tb_timebase_prescaler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timebase_prescaler.sv
// -----------------------------------------------------------------------------
// timebase_prescaler
//
// Free-running prescaler for the clock timebase. It counts clk cycles from 0
// up to TERMINAL, wraps to 0, and produces a registered one-cycle tick on the
// wrap. The count bus feeds the downstream terminal-count comparator. A
// run/hold/idle FSM lets the time-set logic pause, resume and clear the count.
// A blink output toggles on each tick to drive the display colon.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   level command: begin/resume counting (lowest priority)
//   stop     in   level command: freeze the counter (beats start)
//   clear    in   level command: zero the counter (beats stop and start)
//   count    out  [0:WIDTH-1] current count, bit 0 is the MSB
//   tick     out  one-cycle pulse in the cycle count shows 0 after a wrap
//   blink    out  toggles on every tick
//   running  out  high while the FSM is in RUN
//
// Every output comes straight from a flop, so there is no combinational path
// from the command inputs to any output.
// -----------------------------------------------------------------------------
module timebase_prescaler #(
  parameter int unsigned WIDTH    = 27,
  parameter int unsigned TERMINAL = 99999999   // must be < 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [0:WIDTH-1] count,
  output logic             tick,
  output logic             blink,
  output logic             running
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // stopped, count is zero
    RUN  = 2'd1,   // counting
    HOLD = 2'd2    // stopped, count retained
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic             tick_q,  tick_d;
  logic             blink_q, blink_d;
  logic             run_q;

  // Anything at or above TERMINAL is treated as terminal, so a corrupted
  // count can never run on past the period.
  logic at_terminal;
  assign at_terminal = (cnt_q >= TERM_VAL);

  // ---------------------------------------------------------------------------
  // State register. All outputs are registered here alongside the FSM state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      run_q   <= (state_d == RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: clear > stop > start.
  // ---------------------------------------------------------------------------
  // NOTE: a default assignment at the top of each combinational block keeps
  // every path assigned, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!clear && !stop && start) state_d = RUN;
      end
      RUN: begin
        // clear keeps counting from zero; only stop leaves RUN.
        if (!clear && stop) state_d = HOLD;
      end
      HOLD: begin
        if (clear)      state_d = IDLE;
        else if (stop)  state_d = HOLD;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output/datapath logic: next count, tick and blink.
  // The counter only advances in a cycle that starts and ends in RUN with no
  // command pending, so the cycle that samples start does not increment and
  // a stop in the terminal cycle suppresses the wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    blink_d = blink_q;
    if (clear) begin
      cnt_d = '0;
    end else if (state_q == RUN && !stop) begin
      if (at_terminal) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The descending internal vector maps MSB-first onto the ascending port.
  assign count   = cnt_q;
  assign tick    = tick_q;
  assign blink   = blink_q;
  assign running = run_q;

endmodule

// File: tb/tb_timebase_prescaler.sv
// -----------------------------------------------------------------------------
// tb_timebase_prescaler
//
// Drives timebase_prescaler (TERMINAL=9) with directed scenarios followed by
// random commands and random resets. A behavioural model tracks the mode and
// the count as a modulo-(TERMINAL+1) value and is compared with the DUT every
// cycle; directed scenarios also pin outputs against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_timebase_prescaler;

  localparam int WIDTH    = 27;
  localparam int TERMINAL = 9;
  localparam int PERIOD   = TERMINAL + 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic             clear = 1'b0;
  logic [0:WIDTH-1] count;
  logic             tick;
  logic             blink;
  logic             running;

  int total = 0;
  int bad   = 0;

  timebase_prescaler #(.WIDTH(WIDTH), .TERMINAL(TERMINAL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .count   (count),
    .tick    (tick),
    .blink   (blink),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_RUN, M_HOLD} mode_t;

  mode_t m_mode  = M_IDLE;
  int    m_cnt   = 0;
  bit    m_tick  = 1'b0;
  bit    m_blink = 1'b0;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_cnt   = 0;
    m_tick  = 1'b0;
    m_blink = 1'b0;
  endtask

  // One clock edge worth of behaviour, from the command rules.
  task automatic model_edge(input bit s, input bit p, input bit c);
    m_tick = 1'b0;
    if (c) begin
      m_cnt = 0;
      if (m_mode != M_RUN) m_mode = M_IDLE;
    end else if (p) begin
      if (m_mode == M_RUN) m_mode = M_HOLD;
    end else if (s && m_mode != M_RUN) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_cnt   = (m_cnt + 1) % PERIOD;
      m_tick  = (m_cnt == 0);
      m_blink = m_blink ^ m_tick;
    end
  endtask

  always @(negedge rst_n) model_reset();

  // Model update at the edge, comparison 2 time units later.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_edge(start, stop, clear);
    #2;
    check("count",   32'(count),   32'(m_cnt));
    check("tick",    32'(tick),    32'(m_tick));
    check("blink",   32'(blink),   32'(m_blink));
    check("running", 32'(running), 32'(m_mode == M_RUN));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic s, input logic p, input logic c);
    @(negedge clk);
    start = s;
    stop  = p;
    clear = c;
    @(posedge clk);
    #3;
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #3;
    check("rst count",   32'(count),   0);
    check("rst tick",    32'(tick),    0);
    check("rst blink",   32'(blink),   0);
    check("rst running", 32'(running), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start from IDLE: ticks at cycles 10 and 20.
    cyc(1'b1, 1'b0, 1'b0);
    check("s1 count0",  32'(count),   0);
    check("s1 running", 32'(running), 1);
    run(9);
    check("s1 count9",  32'(count), 9);
    check("s1 notick",  32'(tick),  0);
    run(1);
    check("s1 wrap",    32'(count), 0);
    check("s1 tick10",  32'(tick),  1);
    check("s1 blink1",  32'(blink), 1);
    run(10);
    check("s1 tick20",  32'(tick),  1);
    check("s1 blink0",  32'(blink), 0);

    // Stop at count 5 for 4 cycles, then resume.
    run(5);
    check("s2 count5",  32'(count), 5);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    check("s2 hold",    32'(count),   5);
    check("s2 stopped", 32'(running), 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("s2 startcyc", 32'(count),   5);
    check("s2 resumed",  32'(running), 1);
    run(1);
    check("s2 count6",  32'(count), 6);

    // stop+start together at count 3, then all three together.
    run(7);
    check("s3 count3",  32'(count), 3);
    cyc(1'b1, 1'b1, 1'b0);
    check("s3 stopwins", 32'(count),   3);
    check("s3 hold",     32'(running), 0);
    cyc(1'b1, 1'b1, 1'b1);
    check("s3 cleared", 32'(count),   0);
    check("s3 idle",    32'(running), 0);
    run(2);
    check("s3 staysidle", 32'(count), 0);

    // Clear during RUN at count 7.
    cyc(1'b1, 1'b0, 1'b0);
    run(7);
    check("s4 count7",  32'(count), 7);
    cyc(1'b0, 1'b0, 1'b1);
    check("s4 clr0",    32'(count),   0);
    check("s4 clrtick", 32'(tick),    0);
    check("s4 stillrun", 32'(running), 1);
    run(9);
    check("s4 count9",  32'(count), 9);
    check("s4 notick",  32'(tick),  0);
    run(1);
    check("s4 tick",    32'(tick),  1);
    check("s4 blink",   32'(blink), 0);

    // Stop in the terminal cycle, then start.
    run(9);
    cyc(1'b0, 1'b1, 1'b0);
    check("s5 hold9",   32'(count),   9);
    check("s5 notick",  32'(tick),    0);
    check("s5 stopped", 32'(running), 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("s5 still9",  32'(count), 9);
    check("s5 notick2", 32'(tick),  0);
    run(1);
    check("s5 wrap",    32'(count), 0);
    check("s5 tick",    32'(tick),  1);
    check("s5 blink1",  32'(blink), 1);

    // Asynchronous reset mid-cycle at count 6, blink 1.
    run(6);
    check("s6 count6",  32'(count), 6);
    check("s6 blink1",  32'(blink), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s6 rcount",   32'(count),   0);
    check("s6 rblink",   32'(blink),   0);
    check("s6 rtick",    32'(tick),    0);
    check("s6 rrunning", 32'(running), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(5);
    check("s6 idle0",   32'(count),   0);
    check("s6 idlerun", 32'(running), 0);

    // Random commands with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 13) == 0);
      clear = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
